// File: rtl/sdm_feed_ctrl.sv
// sdm_feed_ctrl
// Sample scheduler and soft-mute controller in front of the 1-bit
// sigma-delta modulator. Once per oversampling period it pulls one PCM
// sample from the upstream valid/ready source and holds it on the
// modulator input for the whole period. On enable/disable it ramps a
// gain linearly between midscale and the signal, so the 1-bit stream
// never clicks on start or stop. Missing samples are flagged as underruns.
// Everything runs in the clk_fast domain.

`timescale 1ns/1ps

module sdm_feed_ctrl #(
  parameter int W     = 12,
  parameter int OSR_W = 8,
  parameter int G_W   = 6
) (
  input  logic             clk_fast,
  input  logic             rst,
  input  logic             enable,
  input  logic [OSR_W-1:0] osr,
  input  logic [W-1:0]     s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [W-1:0]     sdm_din,
  output logic             underrun,
  output logic             underrun_sticky,
  input  logic             clr_flags,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RAMP_UP = 2'd1,
    ST_RUN     = 2'd2,
    ST_RAMP_DN = 2'd3
  } state_t;

  // Midscale of the unsigned offset-binary sample, full gain and unit gain.
  localparam logic [W-1:0]   MID    = {1'b1, {(W-1){1'b0}}};
  localparam logic [G_W:0]   G_FULL = {1'b1, {G_W{1'b0}}};
  localparam logic [G_W:0]   G_ONE  = {{G_W{1'b0}}, 1'b1};
  localparam int             PW     = W + G_W + 2;

  state_t             st;
  state_t             st_nxt;
  logic [OSR_W-1:0]   cnt;
  logic [G_W:0]       g;
  logic [G_W:0]       g_nxt;
  logic [W-1:0]       hold;
  logic [W-1:0]       hold_nxt;
  logic [W-1:0]       din_nxt;
  logic signed [W:0]  d;
  logic signed [PW-1:0] p;
  logic               tick;
  logic               active;
  logic               xfer;
  logic               unused_p_bits;

  // The >= compare makes a lowered osr wrap immediately instead of
  // counting all the way round the counter first.
  assign tick   = (cnt >= osr);
  assign active = (st != ST_IDLE);

  // One transfer slot per period; a reset cycle never accepts or flags anything.
  assign s_ready  = tick && active && !rst;
  assign underrun = tick && active && !s_valid && !rst;
  assign xfer     = s_ready && s_valid;
  assign state    = st;

  // Next-state, gain and held-sample decisions; all of them move only on a tick.
  always_comb begin
    st_nxt   = st;
    g_nxt    = g;
    hold_nxt = hold;
    if (xfer) begin
      hold_nxt = s_data;
    end
    if (tick) begin
      case (st)
        ST_IDLE: begin
          g_nxt = '0;
          if (enable) begin
            st_nxt = ST_RAMP_UP;
          end
        end
        ST_RAMP_UP: begin
          // A reversal out of a ramp-down can re-enter here already at full
          // gain, so saturate rather than step past 2^G_W.
          if (!enable) begin
            st_nxt = ST_RAMP_DN;
          end else if (g >= G_FULL - G_ONE) begin
            g_nxt  = G_FULL;
            st_nxt = ST_RUN;
          end else begin
            g_nxt = g + G_ONE;
          end
        end
        ST_RUN: begin
          g_nxt = G_FULL;
          if (!enable) begin
            st_nxt = ST_RAMP_DN;
          end
        end
        ST_RAMP_DN: begin
          // A disable on the very first ramp-up tick arrives here with g=0,
          // so treat g<=1 as the last step instead of wrapping below zero.
          if (enable) begin
            st_nxt = ST_RAMP_UP;
          end else if (g <= G_ONE) begin
            g_nxt    = '0;
            st_nxt   = ST_IDLE;
            hold_nxt = MID;
          end else begin
            g_nxt = g - G_ONE;
          end
        end
        default: begin
          st_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Gain scaling around midscale: MID + floor((hold-MID)*g / 2^G_W), taken
  // from the post-tick values so the output lands one cycle after the tick.
  always_comb begin
    d = $signed({1'b0, hold_nxt}) - $signed({1'b0, MID});
    p = $signed({{(G_W+1){d[W]}}, d}) * $signed({{(W+1){1'b0}}, g_nxt});
    din_nxt = MID + p[W+G_W-1:G_W];
    unused_p_bits = ^{p[G_W-1:0], p[PW-1:W+G_W]};
  end

  // State, period counter, datapath registers and the sticky underrun flag.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      st              <= ST_IDLE;
      cnt             <= '0;
      g               <= '0;
      hold            <= MID;
      sdm_din         <= MID;
      underrun_sticky <= 1'b0;
    end else begin
      st      <= st_nxt;
      cnt     <= tick ? '0 : cnt + 1'b1;
      g       <= g_nxt;
      hold    <= hold_nxt;
      sdm_din <= din_nxt;
      if (underrun) begin
        underrun_sticky <= 1'b1;
      end else if (clr_flags) begin
        underrun_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: doc/sdm_feed_ctrl.md
Name: sdm_feed_ctrl

Overview:
- Sample scheduler and soft-mute controller for the 1-bit sigma-delta modulator.
- Pulls PCM samples from an upstream valid/ready source once per programmable oversampling period.
- Holds each sample on the modulator input for the whole period.
- Applies a linear gain ramp between midscale and signal on enable/disable, so the 1-bit output never clicks on start/stop.
- Detects and flags underruns.

Parameters:
- W, 12: sample width and modulator input width (unsigned, midscale MID = 2^(W-1)).
- OSR_W, 8: width of the oversampling period register.
- G_W, 6: ramp resolution; a full ramp takes 2^G_W ticks.

Ports:
- clk_fast  in  1  modulator clock; everything runs in this domain.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = play (ramp up / run), 0 = mute (ramp down / idle).
- osr  in  OSR_W  period minus 1, in clk_fast cycles (0 = tick every cycle).
- s_data  in  W  upstream sample, unsigned offset-binary.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  sample accepted this cycle when s_valid && s_ready.
- sdm_din  out  W  registered modulator input.
- underrun  out  1  one-cycle pulse on an underrun.
- underrun_sticky  out  1  set by underrun, cleared by clr_flags or rst.
- clr_flags  in  1  clears underrun_sticky; set wins if it coincides with a new underrun.
- state  out  2  IDLE=0, RAMP_UP=1, RUN=2, RAMP_DN=3.

Behaviour:
- Reset values:
  - state IDLE; period counter cnt 0; gain g 0; held sample hold = MID.
  - sdm_din = MID; underrun 0; underrun_sticky 0; s_ready 0.
- Tick generator:
  - tick = (cnt >= osr). On tick, cnt <= 0; otherwise cnt <= cnt+1. Free-running in all states.
  - Comparing with >= makes a mid-run decrease of osr wrap at once, never after 2^OSR_W cycles.
- Handshake:
  - s_ready = tick && (state != IDLE), combinational; at most one sample per period.
  - A transfer loads hold <= s_data.
  - s_valid without s_ready is held off and not consumed.
  - In IDLE nothing is consumed.
- Underrun:
  - Raised on tick with state in {RAMP_UP, RUN, RAMP_DN} and !s_valid.
  - underrun pulses in that cycle and hold keeps its previous value.
- Gain and FSM (updates only on tick):
  - IDLE: g = 0. If enable, go to RAMP_UP.
  - RAMP_UP: g <= g+1. When g reaches 2^G_W, go to RUN. If enable=0, go to RAMP_DN with g unchanged this tick.
  - RUN: g = 2^G_W. If enable=0, go to RAMP_DN.
  - RAMP_DN: g <= g-1. When g reaches 0, go to IDLE and set hold <= MID. If enable=1, go to RAMP_UP with g unchanged this tick.
  - enable is sampled only on tick; toggles between ticks are ignored.
- Output arithmetic:
  - d = hold - MID, as a W+1-bit signed value.
  - p = d * g, signed, W+G_W+2 bits.
  - sdm_din = MID + (p >>> G_W), arithmetic shift, floor rounding.
  - Result always fits in W bits; at g = 2^G_W, sdm_din == hold exactly.
- Latency:
  - sdm_din is registered and updates in the cycle after a tick, using post-tick hold and g.
  - sdm_din is constant between ticks.
- Reset mid-operation: immediate return to reset values on the next edge; an in-flight handshake is dropped (s_ready 0).

Test Plan:
- Reset/idle:
  - Stimulus: assert rst 3 cycles, osr=3, enable=0, s_valid=1.
  - Required: sdm_din=0x800, s_ready never high, state=0, no underrun.
- Ramp up:
  - Stimulus: W=12, G_W=6, osr=3, enable=1, s_valid=1, s_data=0xFFF constant.
  - Required: s_ready pulses every 4 cycles. After the 32nd ramp tick, sdm_din=0x800+(2047*32>>6)=0xBFF. After the 64th tick, state=RUN and sdm_din=0xFFF.
- Underrun:
  - Stimulus: in RUN with hold=0x900, drop s_valid for one tick.
  - Required: underrun pulses exactly once, underrun_sticky=1, sdm_din stays 0x900. Next valid sample 0x700 appears on sdm_din one cycle after its tick.
- Reversal:
  - Stimulus: deassert enable at g=10 during RAMP_UP, then reassert at g=4 in RAMP_DN.
  - Required: g counts 10→4, then back up; no jump on sdm_din; state goes 1→3→1.
- Full mute:
  - Stimulus: s_data=0x000 in RUN, then enable=0.
  - Required: after 64 ticks, state=IDLE and sdm_din=0x800. Values are monotonically non-decreasing from 0x000. s_ready stays 0 afterwards.
- Edge cases:
  - Stimulus: osr=0, then change osr from 200 to 5 while cnt=100; separately, pulse rst in RUN.
  - Required: with osr=0, tick and s_ready every cycle. After the osr change, a tick occurs on the next cycle, then every 6 cycles. After rst, all reset values hold the next cycle.
